// File: rtl/projeto_200917_qsys_pio_out_pulse.sv
// Avalon-MM parallel output port with set/clear/toggle registers and a timed pulse generator.
// Zero-wait-state combinational reads; out_port is registered with no combinational path from the bus.
module projeto_200917_qsys_pio_out_pulse #(
    parameter int unsigned              DATA_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE   = '0,
    parameter int unsigned              PW_BITS       = 16,
    parameter logic [PW_BITS-1:0]       PULSE_DEFAULT = PW_BITS'(1000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  busy
);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_PULSELEN = 3'd2;
    localparam logic [2:0] A_PULSE    = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;
    localparam logic [2:0] A_TOGGLE   = 3'd6;
    localparam logic [2:0] A_STATUS   = 3'd7;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] pulse_mask_q, pulse_mask_d;
    logic [PW_BITS-1:0]    cnt_q, cnt_d;
    logic [PW_BITS-1:0]    pulse_len_q, pulse_len_d;
    logic [0:0]            state_q, state_d;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [PW_BITS-1:0]    load_len;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    // A programmed length of zero still yields a one-cycle pulse.
    assign load_len  = (pulse_len_q == '0) ? PW_BITS'(1) : pulse_len_q;

    always_comb begin
        data_out_d   = data_out_q;
        pulse_mask_d = pulse_mask_q;
        cnt_d        = cnt_q;
        pulse_len_d  = pulse_len_q;
        state_d      = state_q;

        // Expiry is resolved first so that a same-edge bus write overrides it.
        if (state_q == ACTIVE) begin
            cnt_d = cnt_q - PW_BITS'(1);
            if (cnt_q == PW_BITS'(1)) begin
                data_out_d   = data_out_q & ~pulse_mask_q;
                pulse_mask_d = '0;
                cnt_d        = '0;
                state_d      = IDLE;
            end
        end

        if (wr) begin
            case (address)
                A_DATA: begin
                    data_out_d   = wd;
                    pulse_mask_d = '0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end
                A_PULSELEN: pulse_len_d = writedata[PW_BITS-1:0];
                A_PULSE: begin
                    if (wd != '0) begin
                        data_out_d   = data_out_d | wd;
                        pulse_mask_d = pulse_mask_d | wd;
                        cnt_d        = load_len;
                        state_d      = ACTIVE;
                    end
                end
                A_OUTSET:   data_out_d = data_out_d | wd;
                A_OUTCLEAR: begin
                    data_out_d   = data_out_d & ~wd;
                    pulse_mask_d = pulse_mask_d & ~wd;
                end
                A_TOGGLE:   data_out_d = data_out_d ^ wd;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= RESET_VALUE;
            pulse_mask_q <= '0;
            cnt_q        <= '0;
            pulse_len_q  <= PULSE_DEFAULT;
            state_q      <= IDLE;
        end else begin
            data_out_q   <= data_out_d;
            pulse_mask_q <= pulse_mask_d;
            cnt_q        <= cnt_d;
            pulse_len_q  <= pulse_len_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:     readdata = 32'(data_out_q);
            A_PULSELEN: readdata = 32'(pulse_len_q);
            A_PULSE:    readdata = 32'(pulse_mask_q);
            A_STATUS:   readdata = {31'd0, busy};
            default:    readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_projeto_200917_qsys_pio_out_pulse.sv
// Directed bench: table of single-write vectors, then hand-built multi-cycle pulse sequences.
module tb_projeto_200917_qsys_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    projeto_200917_qsys_pio_out_pulse dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    typedef struct {
        logic        cs;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [3:0]  exp_out;
        logic        exp_busy;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_state(input string name, input logic [3:0] eo, input logic eb);
        chk({name, ".out"}, 32'(out_port), 32'(eo));
        chk({name, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    // Presents one write for exactly one rising edge; returns 1 unit after that edge.
    task automatic bus_write(input logic cs_v, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = cs_v;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;

        vecs[0]  = '{1'b1, 3'd0, 32'h0000_0005,  4'h5, 1'b0, 3'd0, 32'h5};
        vecs[1]  = '{1'b1, 3'd4, 32'h0000_0002,  4'h7, 1'b0, 3'd4, 32'h0};
        vecs[2]  = '{1'b1, 3'd5, 32'h0000_0004,  4'h3, 1'b0, 3'd5, 32'h0};
        vecs[3]  = '{1'b1, 3'd6, 32'h0000_0009,  4'hA, 1'b0, 3'd6, 32'h0};
        vecs[4]  = '{1'b1, 3'd1, 32'hFFFF_FFFF,  4'hA, 1'b0, 3'd1, 32'h0};
        vecs[5]  = '{1'b1, 3'd2, 32'h0001_2345,  4'hA, 1'b0, 3'd2, 32'h2345};
        vecs[6]  = '{1'b1, 3'd0, 32'hFFFF_FFF3,  4'h3, 1'b0, 3'd0, 32'h3};
        vecs[7]  = '{1'b1, 3'd3, 32'h0000_0000,  4'h3, 1'b0, 3'd7, 32'h0};
        vecs[8]  = '{1'b0, 3'd0, 32'h0000_0000,  4'h3, 1'b0, 3'd0, 32'h3};
        vecs[9]  = '{1'b1, 3'd0, 32'h0000_0000,  4'h0, 1'b0, 3'd0, 32'h0};
        vecs[10] = '{1'b1, 3'd2, 32'h0000_0003,  4'h0, 1'b0, 3'd2, 32'h3};

        // Reset values
        #12;
        chk_state("reset", 4'h0, 1'b0);
        rd_chk("reset.rd_data", 3'd0, 32'h0);
        rd_chk("reset.rd_len", 3'd2, 32'd1000);
        rd_chk("reset.rd_status", 3'd7, 32'h0);
        rd_chk("reset.rd_mask", 3'd3, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].cs, vecs[i].addr, vecs[i].wd);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy);
            rd_chk($sformatf("vec%0d.rd", i), vecs[i].raddr, vecs[i].exp_rd);
        end

        // 3-cycle pulse on bit0 (PULSE_LEN already 3)
        bus_write(1'b1, 3'd3, 32'h1);
        chk_state("p3.c0", 4'h1, 1'b1);
        rd_chk("p3.mask", 3'd3, 32'h1);
        rd_chk("p3.status", 3'd7, 32'h1);
        step(); chk_state("p3.c1", 4'h1, 1'b1);
        step(); chk_state("p3.c2", 4'h1, 1'b1);
        step(); chk_state("p3.end", 4'h0, 1'b0);
        rd_chk("p3.mask_end", 3'd3, 32'h0);

        // Retrigger: bit0 high 6 cycles, bit1 high 4, common expiry
        bus_write(1'b1, 3'd2, 32'h4);
        bus_write(1'b1, 3'd3, 32'h1);
        chk_state("rt.c0", 4'h1, 1'b1);
        step(); chk_state("rt.c1", 4'h1, 1'b1);
        bus_write(1'b1, 3'd3, 32'h2);
        chk_state("rt.c2", 4'h3, 1'b1);
        step(); chk_state("rt.c3", 4'h3, 1'b1);
        step(); chk_state("rt.c4", 4'h3, 1'b1);
        step(); chk_state("rt.c5", 4'h3, 1'b1);
        step(); chk_state("rt.end", 4'h0, 1'b0);

        // DATA write cancels a running pulse
        bus_write(1'b1, 3'd2, 32'h5);
        bus_write(1'b1, 3'd3, 32'h3);
        chk_state("cancel.c0", 4'h3, 1'b1);
        bus_write(1'b1, 3'd0, 32'h8);
        chk_state("cancel.data", 4'h8, 1'b0);
        rd_chk("cancel.mask", 3'd3, 32'h0);
        for (int k = 0; k < 6; k++) step();
        chk_state("cancel.hold", 4'h8, 1'b0);

        // Zero length gives a single-cycle pulse
        bus_write(1'b1, 3'd2, 32'h0);
        bus_write(1'b1, 3'd3, 32'h1);
        chk_state("len0.c0", 4'h9, 1'b1);
        step(); chk_state("len0.end", 4'h8, 1'b0);

        // Bus write on the expiry edge wins over the expiry clear
        bus_write(1'b1, 3'd0, 32'h0);
        bus_write(1'b1, 3'd2, 32'h2);
        bus_write(1'b1, 3'd3, 32'h1);
        chk_state("prec.c0", 4'h1, 1'b1);
        @(posedge clk);
        bus_write(1'b1, 3'd4, 32'h1);
        chk_state("prec.set", 4'h1, 1'b0);

        // OUTCLEAR empties the mask; FSM still runs out its count
        bus_write(1'b1, 3'd0, 32'h0);
        bus_write(1'b1, 3'd2, 32'h3);
        bus_write(1'b1, 3'd3, 32'h2);
        bus_write(1'b1, 3'd5, 32'h2);
        chk_state("oc.clr", 4'h0, 1'b1);
        rd_chk("oc.mask", 3'd3, 32'h0);
        bus_write(1'b1, 3'd4, 32'h2);
        chk_state("oc.set", 4'h2, 1'b1);
        step(); chk_state("oc.end", 4'h2, 1'b0);

        // PULSE_LEN change mid-pulse leaves the running count alone
        bus_write(1'b1, 3'd0, 32'h0);
        bus_write(1'b1, 3'd2, 32'h2);
        bus_write(1'b1, 3'd3, 32'h4);
        bus_write(1'b1, 3'd2, 32'h7);
        chk_state("len_mid.c1", 4'h4, 1'b1);
        step(); chk_state("len_mid.end", 4'h0, 1'b0);
        rd_chk("len_mid.rd_len", 3'd2, 32'h7);

        // Asynchronous reset in the middle of a long pulse
        bus_write(1'b1, 3'd2, 32'hA);
        bus_write(1'b1, 3'd3, 32'hF);
        chk_state("ar.c0", 4'hF, 1'b1);
        step();
        step();
        #1;
        reset = 1'b1;
        #1;
        chk_state("ar.reset", 4'h0, 1'b0);
        rd_chk("ar.rd_len", 3'd2, 32'd1000);
        rd_chk("ar.rd_mask", 3'd3, 32'h0);

        // First edge after reset release accepts a write
        @(negedge clk);
        reset      = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h5;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk_state("ar.first_wr", 4'h5, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/projeto_200917_qsys_pio_out_pulse.md
PROJETO_200917_QSYS_PIO_OUT_PULSE -- requirements
Module: projeto_200917_qsys_pio_out_pulse

Interface
REQ-001 Parameter DATA_WIDTH, default 4, output port width, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, out_port value after reset, DATA_WIDTH bits.
REQ-003 Parameter PW_BITS, default 16, pulse-length counter width, legal range 1..32.
REQ-004 Parameter PULSE_DEFAULT, default 1000, PULSE_LEN value after reset.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, combinational from address, zero wait states.
REQ-012 out_port  output  DATA_WIDTH  registered parallel output.
REQ-013 busy  output  1  high while a timed pulse is active.

Function
REQ-014 Write strobe wr = chipselect & ~write_n; no effect when wr low.
REQ-015 Address map: 0 DATA (R/W), 1 reserved (reads 0, writes ignored), 2 PULSE_LEN (R/W, PW_BITS), 3 PULSE (W; reads pulse_mask), 4 OUTSET (W, reads 0), 5 OUTCLEAR (W, reads 0), 6 TOGGLE (W, reads 0), 7 STATUS (RO: bit0 busy, others 0).
REQ-016 Reads: selected field zero-extended to 32 bits; writedata bits above the field width ignored on writes.
REQ-017 DATA write: data_out <= writedata[DATA_WIDTH-1:0]; cancels any active pulse (pulse_mask <= 0, counter <= 0, state IDLE).
REQ-018 OUTSET write: data_out |= wd; OUTCLEAR write: data_out &= ~wd and pulse_mask &= ~wd; TOGGLE write: data_out ^= wd.
REQ-019 Pulse FSM states IDLE and ACTIVE; busy = (state == ACTIVE).
REQ-020 PULSE write with wd != 0: data_out |= wd, pulse_mask <= pulse_mask | wd, counter <= max(PULSE_LEN, 1), state ACTIVE; PULSE write with wd == 0 has no effect.
REQ-021 Retrigger: a PULSE write in ACTIVE merges masks and reloads counter (all masked bits share the new expiry).
REQ-022 ACTIVE: counter decrements each cycle; on the cycle counter == 1: data_out &= ~pulse_mask, pulse_mask <= 0, state IDLE.
REQ-023 Pulse duration: masked bits high for exactly max(PULSE_LEN,1) cycles, counted from the first edge after the write edge.
REQ-024 Same-cycle precedence: expiry clear is applied first, then the bus write (DATA/OUTSET/OUTCLEAR/TOGGLE/PULSE) on the same edge overrides it.
REQ-025 If OUTCLEAR empties pulse_mask, FSM remains ACTIVE until counter expires (expiry then clears nothing).
REQ-026 PULSE_LEN write during ACTIVE does not affect the running counter; it applies to the next PULSE write.
REQ-027 out_port = data_out; no combinational path from bus inputs to out_port.

Reset
REQ-028 On reset asserted (any time, including mid-pulse): data_out = RESET_VALUE, pulse_mask = 0, counter = 0, state IDLE, busy = 0, PULSE_LEN = PULSE_DEFAULT.
REQ-029 Reset release: first write accepted on the first rising edge with reset low.

Verification
REQ-030 Reset, read addr 0/2/7 -> readdata = RESET_VALUE, PULSE_DEFAULT, 0; out_port = RESET_VALUE.
REQ-031 DATA=0x5, OUTSET=0x2, OUTCLEAR=0x4, TOGGLE=0x9 -> out_port 0x5, 0x7, 0x3, 0xA.
REQ-032 PULSE_LEN=3, DATA=0, PULSE=0x1 -> out_port bit0 high exactly 3 cycles, busy high same 3 cycles, then 0x0.
REQ-033 PULSE_LEN=4, PULSE=0x1, two cycles later PULSE=0x2 -> bit0 high 6 cycles, bit1 high 4 cycles, both clear on the same edge.
REQ-034 PULSE=0x3 (PULSE_LEN=5), DATA=0x8 during pulse -> out_port 0x8 immediately, busy 0, remains 0x8; PULSE_LEN=0 then PULSE=0x1 -> 1-cycle pulse.
REQ-035 PULSE=0xF (PULSE_LEN=10), reset asserted mid-pulse -> out_port = RESET_VALUE asynchronously, busy 0, PULSE_LEN reads PULSE_DEFAULT.
